uart_mmio: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the CPU data bus, in the same 0x4000_00xx peripheral window as the timer, LED, switch and 7-seg registers.
- Shares Addr/WriteData/MemRd/MemWr with the data memory and peripheral block.
- Its ReadData is ORed into the bus read mux by the bus owner; its interrupt is ORed into the CPU interrupt line.
- Provides one TX and one RX channel, each with status flags and an interrupt.

---
 rtl/uart_mmio.sv | 210 +++++++++++++++++++++
 tb/tb_uart_mmio.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, TX and RX FSMs, level interrupt.
// Optional build macro UART_LOOPBACK_EN adds CON bit7 internal tx->rx loopback.
module uart_mmio #(
  parameter int unsigned CLK_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemRd,
  input  logic        MemWr,
  output logic [31:0] ReadData,
  input  logic        rx,
  output logic        tx,
  output logic        uart_irq
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [29:0] A_TXD = BASE_ADDR[31:2];
  localparam logic [29:0] A_RXD = A_TXD + 30'd1;
  localparam logic [29:0] A_CON = A_TXD + 30'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;

  tx_state_t tx_state, tx_state_d;
  rx_state_t rx_state, rx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d, rx_cnt, rx_cnt_d;
  logic [2:0] tx_bit, tx_bit_d, rx_bit, rx_bit_d;
  logic [7:0] tx_shift, tx_shift_d, rx_shift, rx_shift_d, rx_data;
  logic tx_q, tx_q_d, tx_busy, tx_busy_d;
  logic [1:0] rx_sync;
  logic rx_prev, rx_in_c;
  logic rx_irq_en, tx_irq_en, rx_valid, rx_overrun, frame_err, tx_done, loop;
  logic sel_txd_c, sel_rxd_c, sel_con_c, wr_con_c, rd_rxd_c, rd_con_c;
  logic tx_fin_c, tx_accept_c, rx_ok_c, rx_ferr_c;
  logic [7:0] con_c;
  logic unused_bits;

  assign unused_bits = ^{Addr[1:0], WriteData[31:8]};

  assign sel_txd_c   = (Addr[31:2] == A_TXD);
  assign sel_rxd_c   = (Addr[31:2] == A_RXD);
  assign sel_con_c   = (Addr[31:2] == A_CON);
  assign wr_con_c    = MemWr & sel_con_c;
  assign rd_rxd_c    = MemRd & sel_rxd_c;
  assign rd_con_c    = MemRd & sel_con_c;
  assign tx_fin_c    = (tx_state == TX_STOP) && (tx_cnt == BIT_LAST);
  // The last STOP cycle already frees the transmitter for a back-to-back write.
  assign tx_accept_c = MemWr & sel_txd_c & (~tx_busy | tx_fin_c);

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (!reset)        loop <= 1'b0;
    else if (wr_con_c) loop <= WriteData[7];
  end
`else
  assign loop = 1'b0;
`endif

  assign rx_in_c = loop ? tx_q : rx;
  assign tx      = tx_q | loop;
  assign con_c   = {loop, frame_err, rx_overrun, tx_done, tx_busy, rx_valid, tx_irq_en, rx_irq_en};

  always_comb begin
    ReadData = 32'h0;
    if (rd_rxd_c)      ReadData = {24'h0, rx_data};
    else if (rd_con_c) ReadData = {24'h0, con_c};
  end

  // TX next state: bit timing and serial output.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 16'd1;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_q_d     = tx_q;
    tx_busy_d  = tx_busy;
    case (tx_state)
      TX_IDLE: tx_cnt_d = '0;
      TX_START:
        if (tx_cnt == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_q_d     = tx_shift[0];
        end
      TX_DATA:
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_q_d     = 1'b1;
          end else begin
            tx_bit_d   = tx_bit + 3'd1;
            tx_shift_d = {1'b0, tx_shift[7:1]};
            tx_q_d     = tx_shift[1];
          end
        end
      TX_STOP:
        if (tx_fin_c) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
          tx_busy_d  = 1'b0;
        end
    endcase
    if (tx_accept_c) begin
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_bit_d   = 3'd0;
      tx_shift_d = WriteData[7:0];
      tx_q_d     = 1'b0;
      tx_busy_d  = 1'b1;
    end
  end

  // RX next state: mid-bit sampling of the synchronized line.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 16'd1;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_ok_c    = 1'b0;
    rx_ferr_c  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev & ~rx_sync[1]) rx_state_d = RX_START;
      end
      RX_START:
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync[1] ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync[1], rx_shift[7:1]};
          rx_bit_d   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end
      RX_STOP:
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync[1]) begin
            rx_ok_c    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_c  = 1'b1;
            rx_state_d = RX_BRK;
          end
        end
      RX_BRK: begin
        rx_cnt_d = '0;
        if (rx_sync[1]) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= 3'd0;
      tx_shift   <= 8'h0;
      tx_q       <= 1'b1;
      tx_busy    <= 1'b0;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'h0;
      rx_sync    <= 2'b11;
      rx_prev    <= 1'b1;
      rx_data    <= 8'h0;
      rx_irq_en  <= 1'b0;
      tx_irq_en  <= 1'b0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_done    <= 1'b0;
      uart_irq   <= 1'b0;
    end else begin
      tx_state   <= tx_state_d;
      tx_cnt     <= tx_cnt_d;
      tx_bit     <= tx_bit_d;
      tx_shift   <= tx_shift_d;
      tx_q       <= tx_q_d;
      tx_busy    <= tx_busy_d;
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_bit     <= rx_bit_d;
      rx_shift   <= rx_shift_d;
      rx_sync    <= {rx_sync[0], rx_in_c};
      rx_prev    <= rx_sync[1];
      if (rx_ok_c) rx_data <= rx_shift;
      if (wr_con_c) {tx_irq_en, rx_irq_en} <= WriteData[1:0];
      // Flag sets take priority over read-side clears.
      rx_valid   <= rx_ok_c | (rx_valid & ~rd_rxd_c);
      rx_overrun <= (rx_ok_c & rx_valid) | (rx_overrun & ~rd_rxd_c);
      frame_err  <= rx_ferr_c | (frame_err & ~rd_con_c);
      tx_done    <= tx_fin_c | (tx_done & ~rd_con_c);
      uart_irq   <= (rx_irq_en & rx_valid) | (tx_irq_en & tx_done);
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio at CLK_PER_BIT=16: bus reads and tx frames are
// checked by monitors against queued expectations.
module tb_uart_mmio;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] ReadData;
  logic        rx = 1'b1;
  logic        tx;
  logic        uart_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];

  uart_mmio #(.CLK_PER_BIT(16), .BASE_ADDR(32'h4000_0018)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData),
    .MemRd(MemRd), .MemWr(MemWr), .ReadData(ReadData),
    .rx(rx), .tx(tx), .uart_irq(uart_irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; MemWr = 1'b1;
    tick(1);
    MemWr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string n);
    rd_exp_q.push_back(e);
    rd_name_q.push_back(n);
    Addr = a; MemRd = 1'b1;
    tick(1);
    MemRd = 1'b0;
  endtask

  task automatic pin_chk(input string n, input logic act, input logic e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got %b expected %b", n, act, e);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stopb;
    tick(16);
    rx = 1'b1;
  endtask

  // Read monitor: every MemRd cycle consumes one queued expectation.
  initial begin
    logic [31:0] e;
    string n;
    forever begin
      @(negedge clk);
      if (MemRd === 1'b1) begin
        checks++;
        if (rd_exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected got %h expected none", ReadData);
        end else begin
          e = rd_exp_q.pop_front();
          n = rd_name_q.pop_front();
          if (ReadData !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, ReadData, e);
          end
        end
      end
    end
  end

  // TX monitor: decode frames on the tx pin at mid-bit; a reset abandons the frame.
  initial begin
    bit active = 0;
    bit ok = 1;
    int cnt = 0;
    logic [7:0] b = 8'h0;
    logic e;
    logic tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) active = 0;
      else if (!active) begin
        if (tx_prev === 1'b1 && tx === 1'b0) begin
          active = 1; ok = 1; cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == 7 && tx !== 1'b0) ok = 0;
        for (int i = 0; i < 8; i++)
          if (cnt == 23 + 16 * i) b[i] = tx;
        if (cnt == 151) begin
          if (tx !== 1'b1) ok = 0;
          active = 0;
          checks++;
          if (tx_exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_frame_unexpected got %h", b);
          end else begin
            e = 1'b1;
            if (!ok || b !== tx_exp_q[0]) e = 1'b0;
            if (!e) begin
              errors++;
              $display("FAIL tx_frame got %h framing_ok %0d expected %h", b, ok, tx_exp_q[0]);
            end
            void'(tx_exp_q.pop_front());
          end
        end
      end
      tx_prev = tx;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    reset = 1'b1;
    tick(1);
    pin_chk("reset_tx", tx, 1'b1);
    pin_chk("reset_irq", uart_irq, 1'b0);
    bus_rd(A_CON, 32'h0, "reset_con");
    bus_rd(32'h4000_0024, 32'h0, "unmapped_read");

    // TX frame 0xA5, a dropped write mid-frame, busy/done boundary around cycle 160.
    tx_exp_q.push_back(8'hA5);
    bus_wr(A_TXD, 32'hA5);
    tick(49);
    bus_wr(A_TXD, 32'hFF);
    tick(109);
    bus_rd(A_CON, 32'h08, "tx_busy_last_cycle");
    bus_rd(A_CON, 32'h10, "tx_done_set");
    bus_rd(A_CON, 32'h00, "tx_done_cleared");

    // RX single byte with interrupt.
    bus_wr(A_CON, 32'h1);
    bus_rd(A_CON, 32'h01, "con_rx_irq_en");
    send_rx(8'h3C, 1'b1);
    pin_chk("rx_irq_set", uart_irq, 1'b1);
    bus_rd(A_RXD, 32'h3C, "rxd_3c");
    bus_rd(A_CON, 32'h01, "rx_valid_cleared");
    pin_chk("rx_irq_cleared", uart_irq, 1'b0);

    // Overrun.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    tick(4);
    bus_rd(A_CON, 32'h25, "con_overrun");
    bus_rd(A_RXD, 32'h22, "rxd_overwritten");
    bus_rd(A_CON, 32'h01, "overrun_cleared");

    // Short glitch on rx.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    bus_rd(A_CON, 32'h01, "glitch_no_flags");

    // Framing error keeps the previous byte.
    send_rx(8'h44, 1'b1);
    send_rx(8'h77, 1'b0);
    tick(10);
    bus_rd(A_CON, 32'h45, "con_frame_err");
    bus_rd(A_RXD, 32'h44, "rxd_kept");
    bus_rd(A_CON, 32'h01, "frame_err_cleared");

    // Reset during a frame (tx is in data bit1 = 0).
    bus_wr(A_TXD, 32'h55);
    tick(40);
    pin_chk("tx_mid_frame_low", tx, 1'b0);
    reset = 1'b0;
    tick(1);
    pin_chk("tx_on_reset_edge", tx, 1'b1);
    reset = 1'b1;
    tick(1);
    bus_rd(A_CON, 32'h00, "con_after_reset");

`ifdef UART_LOOPBACK_EN
    begin
      int hi_viol = 0;
      bus_wr(A_CON, 32'h81);
      bus_wr(A_TXD, 32'h5A);
      for (int i = 0; i < 175; i++) begin
        if (tx !== 1'b1) hi_viol++;
        tick(1);
      end
      checks++;
      if (hi_viol != 0) begin
        errors++;
        $display("FAIL loop_tx_pin got %0d low cycles expected 0", hi_viol);
      end
      bus_rd(A_RXD, 32'h5A, "loop_rxd");
      bus_rd(A_CON, 32'h91, "loop_con");
    end
`endif

    tick(3);
    checks++;
    if (tx_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got tx %0d rd %0d expected 0", tx_exp_q.size(), rd_exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
